// File: rtl/clk_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// clk_rst_seq_pkg
// Shared types and constants for the USB clock-unit reset sequencer.
//   - clk_seq_state_t : sequencer state encoding
//   - DEF_*           : default cycle counts on the 24 MHz reference clock
//   - USB_FULL_SPEED  : existing USB speed selector used elsewhere in the unit
//   - max_u           : helper for sizing the shared sequencer counter
// -----------------------------------------------------------------------------
package clk_rst_seq_pkg;

    localparam bit USB_FULL_SPEED = 1'b1;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_CPU_UP    = 3'd3,
        S_RUN       = 3'd4,
        S_SUSPEND   = 3'd5
    } clk_seq_state_t;

    // Defaults in 24 MHz reference-clock cycles
    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 24000;
    localparam int unsigned DEF_STABLE_CYCLES  = 240;
    localparam int unsigned DEF_USB_RST_DELAY  = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_rst_seq_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single-bit level signal.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both stages clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output (two cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// -----------------------------------------------------------------------------
// clk_rst_seq
// Clock/reset sequencer for the USB clock unit (24 MHz reference domain).
// Holds the PLL in reset, waits for lock (with timeout and unlimited retry),
// waits for clocks to settle, then releases CPU reset and USB reset in order.
// Gates the USB clock buffer during suspend and restarts on loss of lock.
// Ports:
//   clk_i, rst_ni : reference clock, async active-low reset
//   pll_locked    : PLL lock flag (async, synchronised here)
//   usb_suspend   : suspend level from the USB SIE (synchronised here)
//   pll_areset    : PLL reset, active high
//   cpu_rst_n     : CPU-domain reset, active low
//   usb_rst_n     : USB-domain reset, active low
//   usb_clk_en    : USB clock buffer enable
//   clk_ok        : clocks running (S_RUN / S_SUSPEND)
//   lock_fail     : sticky lock-timeout flag, cleared only by rst_ni
//   lock_loss_cnt : saturating count of lock losses after lock was achieved
//                   (only with CLK_RST_SEQ_STATS_EN defined)
// Optional feature macro: CLK_RST_SEQ_STATS_EN
// -----------------------------------------------------------------------------
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned USB_RST_DELAY  = DEF_USB_RST_DELAY
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked,
    input  logic       usb_suspend,
    output logic       pll_areset,
    output logic       cpu_rst_n,
    output logic       usb_rst_n,
    output logic       usb_clk_en,
    output logic       clk_ok,
    output logic       lock_fail
`ifdef CLK_RST_SEQ_STATS_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int unsigned MAX_CYC = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                            max_u(STABLE_CYCLES, USB_RST_DELAY));
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] USB_DLY_LAST = CNT_W'(USB_RST_DELAY - 1);

    logic locked_s;
    logic susp_s;

    sync2 u_sync_lock (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    sync2 u_sync_susp (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (usb_suspend),
        .q_o    (susp_s)
    );

    clk_seq_state_t   state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             pll_areset_d, pll_areset_q;
    logic             cpu_rst_n_d, cpu_rst_n_q;
    logic             usb_rst_n_d, usb_rst_n_q;
    logic             usb_clk_en_d, usb_clk_en_q;
    logic             clk_ok_d, clk_ok_q;
    logic             lock_fail_d, lock_fail_q;
    logic             timeout;
    logic             lock_lost;

    // Next-state logic. Lock loss is checked first in every locked state so it
    // always wins over suspend/resume. The counter clears on any transition and
    // otherwise free-runs; in RUN/SUSPEND its value is never used, so wrapping
    // there is harmless.
    always_comb begin
        state_d   = state_q;
        timeout   = 1'b0;
        lock_lost = 1'b0;

        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLL_RST;
                    timeout = 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d   = S_PLL_RST;
                    lock_lost = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_CPU_UP;
                end
            end
            S_CPU_UP: begin
                if (!locked_s) begin
                    state_d   = S_PLL_RST;
                    lock_lost = 1'b1;
                end else if (cnt_q == USB_DLY_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d   = S_PLL_RST;
                    lock_lost = 1'b1;
                end else if (susp_s) begin
                    state_d = S_SUSPEND;
                end
            end
            S_SUSPEND: begin
                if (!locked_s) begin
                    state_d   = S_PLL_RST;
                    lock_lost = 1'b1;
                end else if (!susp_s) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state and registered, so they switch
    // on the same edge as the state register (lock loss reasserts all resets
    // together with pll_areset in one edge).
    always_comb begin
        pll_areset_d = (state_d == S_PLL_RST);
        cpu_rst_n_d  = (state_d == S_CPU_UP) || (state_d == S_RUN) || (state_d == S_SUSPEND);
        usb_rst_n_d  = (state_d == S_RUN) || (state_d == S_SUSPEND);
        usb_clk_en_d = (state_d == S_RUN);
        clk_ok_d     = (state_d == S_RUN) || (state_d == S_SUSPEND);
        lock_fail_d  = lock_fail_q | timeout;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_PLL_RST;
            cnt_q        <= '0;
            pll_areset_q <= 1'b1;
            cpu_rst_n_q  <= 1'b0;
            usb_rst_n_q  <= 1'b0;
            usb_clk_en_q <= 1'b0;
            clk_ok_q     <= 1'b0;
            lock_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_areset_q <= pll_areset_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            usb_rst_n_q  <= usb_rst_n_d;
            usb_clk_en_q <= usb_clk_en_d;
            clk_ok_q     <= clk_ok_d;
            lock_fail_q  <= lock_fail_d;
        end
    end

    assign pll_areset = pll_areset_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign usb_rst_n  = usb_rst_n_q;
    assign usb_clk_en = usb_clk_en_q;
    assign clk_ok     = clk_ok_q;
    assign lock_fail  = lock_fail_q;

`ifdef CLK_RST_SEQ_STATS_EN
    logic [7:0] loss_cnt_d, loss_cnt_q;

    // Counts only losses after lock was seen; WAIT_LOCK timeouts are excluded.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) loss_cnt_q <= 8'd0;
        else         loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    logic unused_lock_lost;
    assign unused_lock_lost = lock_lost;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_seq
// Self-checking bench for clk_rst_seq with small cycle counts. A behavioural
// model tracks the current phase and the cycles left in it, and predicts the
// outputs every cycle while directed and random lock/suspend activity runs.
// -----------------------------------------------------------------------------
module tb_clk_rst_seq;

    localparam int unsigned T_PLL  = 4;
    localparam int unsigned T_TO   = 32;
    localparam int unsigned T_STAB = 8;
    localparam int unsigned T_USB  = 2;

    localparam int PH_PLL  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_CPU  = 3;
    localparam int PH_RUN  = 4;
    localparam int PH_SUSP = 5;

    logic clk;
    logic rst_n;
    logic pll_locked;
    logic usb_suspend;
    logic pll_areset, cpu_rst_n, usb_rst_n, usb_clk_en, clk_ok, lock_fail;
`ifdef CLK_RST_SEQ_STATS_EN
    logic [7:0] lock_loss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    clk_rst_seq #(
        .PLL_RST_CYCLES (T_PLL),
        .LOCK_TIMEOUT   (T_TO),
        .STABLE_CYCLES  (T_STAB),
        .USB_RST_DELAY  (T_USB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pll_locked    (pll_locked),
        .usb_suspend   (usb_suspend),
        .pll_areset    (pll_areset),
        .cpu_rst_n     (cpu_rst_n),
        .usb_rst_n     (usb_rst_n),
        .usb_clk_en    (usb_clk_en),
        .clk_ok        (clk_ok),
        .lock_fail     (lock_fail)
`ifdef CLK_RST_SEQ_STATS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase plus cycles remaining in it; the inputs are seen
    // two edges late to account for the synchronisers.
    int ph;
    int left;
    bit lk1, lk2, su1, su2, ls, ss;
    bit m_fail;
    int m_loss;

    function automatic int duration(input int p);
        case (p)
            PH_PLL:  return T_PLL;
            PH_WAIT: return T_TO;
            PH_STAB: return T_STAB;
            PH_CPU:  return T_USB;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = PH_PLL; left = T_PLL;
            lk1 = 0; lk2 = 0; su1 = 0; su2 = 0;
            m_fail = 0; m_loss = 0;
        end else begin
            ls = lk2; ss = su2;
            lk2 = lk1; lk1 = pll_locked;
            su2 = su1; su1 = usb_suspend;
            if (ph >= PH_STAB && !ls) begin
                ph = PH_PLL; left = T_PLL;
                if (m_loss < 255) m_loss++;
            end else if (ph == PH_WAIT && ls) begin
                ph = PH_STAB; left = T_STAB;
            end else if (ph == PH_RUN) begin
                if (ss) ph = PH_SUSP;
            end else if (ph == PH_SUSP) begin
                if (!ss) ph = PH_RUN;
            end else begin
                left--;
                if (left == 0) begin
                    if (ph == PH_WAIT) m_fail = 1;
                    ph   = (ph == PH_WAIT) ? PH_PLL : ph + 1;
                    left = duration(ph);
                end
            end
        end
    end

    function automatic logic [5:0] modelOuts();
        logic [5:0] v;
        v[5] = (ph == PH_PLL);
        v[4] = (ph == PH_CPU) || (ph == PH_RUN) || (ph == PH_SUSP);
        v[3] = (ph == PH_RUN) || (ph == PH_SUSP);
        v[2] = (ph == PH_RUN);
        v[1] = (ph == PH_RUN) || (ph == PH_SUSP);
        v[0] = m_fail;
        return v;
    endfunction

    function automatic logic [5:0] dutOuts();
        return {pll_areset, cpu_rst_n, usb_rst_n, usb_clk_en, clk_ok, lock_fail};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkCycle();
        checkOutput("outs", 16'(dutOuts()), 16'(modelOuts()));
`ifdef CLK_RST_SEQ_STATS_EN
        checkOutput("lock_loss_cnt", 16'(lock_loss_cnt), 16'(m_loss));
`endif
    endtask

    // Wait to the next falling edge, compare against the model, then drive
    task automatic applyStimulus(input logic lk, input logic su, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkCycle();
            pll_locked  = lk;
            usb_suspend = su;
        end
    endtask

    initial begin
        int guard;
        bit lk_r, su_r;
        rst_n = 1'b0; pll_locked = 1'b0; usb_suspend = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outs", 16'(dutOuts()), 16'h0020);
        rst_n = 1'b1;

        $display("[TB] power-up, lock at cycle 10");
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 30);
        checkOutput("run_reached", 16'(dutOuts()), 16'h001E);

        $display("[TB] suspend for 20 cycles");
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("resumed", 16'(dutOuts()), 16'h001E);

        $display("[TB] lock loss during suspend");
        applyStimulus(1'b1, 1'b1, 8);
        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("loss_in_susp", 16'(dutOuts()), 16'h0020);
        applyStimulus(1'b1, 1'b0, 30);

        $display("[TB] three lock losses in run");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 5);
            applyStimulus(1'b1, 1'b0, 30);
        end
`ifdef CLK_RST_SEQ_STATS_EN
        checkOutput("loss_cnt_3", 16'(lock_loss_cnt), 16'd4);
`endif

        $display("[TB] lock held low, timeouts");
        applyStimulus(1'b0, 1'b0, 110);
        checkOutput("lock_fail_set", 16'(lock_fail), 16'd1);
        applyStimulus(1'b1, 1'b0, 30);
        checkOutput("lock_fail_sticky", 16'(lock_fail), 16'd1);

        $display("[TB] random lock/suspend activity");
        lk_r = 1'b1; su_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (lk_r) begin
                if ($urandom_range(0, 39) == 0) lk_r = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                lk_r = 1'b1;
            end
            if ($urandom_range(0, 14) == 0) su_r = ~su_r;
            applyStimulus(lk_r, su_r, 1);
        end

        $display("[TB] async reset during stable phase");
        applyStimulus(1'b0, 1'b0, 4);
        guard = 0;
        while (ph != PH_STAB && guard < 200) begin
            applyStimulus(1'b1, 1'b0, 1);
            guard++;
        end
        checkOutput("reach_stable", 16'(guard < 200), 16'd1);
        @(negedge clk);
        checkCycle();
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset", 16'(dutOuts()), 16'h0020);
`ifdef CLK_RST_SEQ_STATS_EN
        checkOutput("async_reset_cnt", 16'(lock_loss_cnt), 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 25);
        checkOutput("restart_run", 16'(dutOuts()), 16'h001E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Clock/reset sequencer for the USB clock unit, running on the 24 MHz reference clock.
- Holds the PLL in reset, waits for lock with a timeout and retry, waits for clocks to stabilise, then releases CPU reset and USB reset in order.
- Gates the USB clock buffer enable during USB suspend.
- Restarts the whole sequence when PLL lock is lost.

Parameters:
- PLL_RST_CYCLES, 16: clk_i cycles that pll_areset is held high.
- LOCK_TIMEOUT, 24000: clk_i cycles to wait for lock before retrying (1 ms).
- STABLE_CYCLES, 240: clk_i cycles after lock before cpu_rst_n is released (10 us).
- USB_RST_DELAY, 8: clk_i cycles between cpu_rst_n release and usb_rst_n release.

Ports:
- clk_i  in  1  24 MHz reference clock.
- rst_ni  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous, synchronised internally.
- usb_suspend  in  1  suspend request from the USB SIE (clk_usb domain); level, synchronised internally.
- pll_areset  out  1  PLL asynchronous reset, active high.
- cpu_rst_n  out  1  CPU-domain reset, active low.
- usb_rst_n  out  1  USB-domain reset, active low.
- usb_clk_en  out  1  enable for the USB clock buffer.
- clk_ok  out  1  high in S_RUN and S_SUSPEND.
- lock_fail  out  1  sticky; set on any lock timeout; cleared only by rst_ni.

Behaviour:
- Reset (rst_ni low, async) state and outputs:
  - state = S_PLL_RST, counter = 0.
  - pll_areset = 1, cpu_rst_n = 0, usb_rst_n = 0, usb_clk_en = 0, clk_ok = 0, lock_fail = 0.
  - Synchronizer flops = 0.
- Synchronisation: pll_locked and usb_suspend each pass through a 2-flop synchroniser. The FSM uses the synchronised versions locked_s and susp_s, giving 2 cycles of input latency.
- Outputs are registered and decoded from the next state, so they change on the same edge the state changes.
- Counter: one shared counter, wide enough for the maximum of the parameters. It clears on every state transition and increments otherwise.
- S_PLL_RST:
  - pll_areset = 1; all resets asserted.
  - When counter == PLL_RST_CYCLES-1, go to S_WAIT_LOCK.
- S_WAIT_LOCK:
  - pll_areset = 0.
  - locked_s = 1: go to S_STABLE.
  - Else, when counter == LOCK_TIMEOUT-1: go to S_PLL_RST and set lock_fail.
  - Retries are unlimited.
- S_STABLE:
  - locked_s = 0: go to S_PLL_RST.
  - Else, when counter == STABLE_CYCLES-1: go to S_CPU_UP.
- S_CPU_UP:
  - cpu_rst_n = 1.
  - locked_s = 0: go to S_PLL_RST.
  - Else, when counter == USB_RST_DELAY-1: go to S_RUN.
- S_RUN:
  - cpu_rst_n = 1, usb_rst_n = 1, usb_clk_en = 1, clk_ok = 1.
  - locked_s = 0: go to S_PLL_RST.
  - Else if susp_s = 1: go to S_SUSPEND.
- S_SUSPEND:
  - usb_clk_en = 0; resets stay released; clk_ok = 1.
  - locked_s = 0: go to S_PLL_RST.
  - Else if susp_s = 0: go to S_RUN, and usb_clk_en returns to 1 on that edge.
- Priority: lock loss beats suspend and resume in every state.
- Lock loss reasserts cpu_rst_n and usb_rst_n (0) and pll_areset (1) on the same edge.
- Lock glitch: a glitch shorter than the synchroniser window may be missed. This is acceptable; the PLL lock output is filtered.
- Timeouts count exact cycles. A parameter value of 1 gives a 1-cycle stay in that state.

Optional Feature:
- Macro: CLK_RST_SEQ_STATS_EN.
- Defined:
  - Adds output lock_loss_cnt [7:0], which increments on each RUN/SUSPEND/STABLE/CPU_UP -> S_PLL_RST transition caused by lock loss.
  - The counter saturates at 255 and resets to 0 on rst_ni.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package types:
  - clk_seq_state_t enum: S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_CPU_UP, S_RUN, S_SUSPEND.
  - Parameter defaults as constants.
  - Existing USB_FULL_SPEED unchanged.
- Sub-module sync2: a 2-flop synchroniser with async active-low reset and reset value 0, instantiated twice.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, USB_RST_DELAY=2):
- Power-up, locked rises at cycle 10 -> pll_areset falls after 4 cycles; cpu_rst_n rises 2+8 cycles after lock; usb_rst_n, usb_clk_en and clk_ok rise 2 cycles later.
- locked held 0 -> pll_areset pulses high for 4 cycles every 36 cycles; lock_fail = 1 after the first timeout and stays 1.
- In S_RUN, usb_suspend = 1 for 20 cycles -> usb_clk_en = 0 from cycle +2 through the suspend, back to 1 two cycles after usb_suspend falls; usb_rst_n stays 1.
- In S_SUSPEND, drop locked -> two cycles later, all resets asserted and pll_areset = 1 on one edge, clk_ok = 0; the full sequence replays after relock.
- Assert rst_ni low mid S_STABLE -> outputs take reset values immediately (asynchronously); after release, the sequence restarts from S_PLL_RST.
- With CLK_RST_SEQ_STATS_EN, 3 lock losses in S_RUN -> lock_loss_cnt = 3; a timeout in S_WAIT_LOCK does not increment it.
